hbus_arbiter: RTL and testbench
===============================

# hbus_arbiter

Two-port arbiter and burst scheduler in front of the `hyperbus` primary controller. It grants the single HyperBus controller to one of two requesters, for example CPU and DMA, using round-robin. Each granted burst is split into segments of at most MAX_BURST words so that CS# low time stays within the device tCSM limit. Beats are routed between the requesters and the controller, and the controller error output plus a beat watchdog are monitored.

## Interface
- ADDR_LENGTH, 32, address width; addresses are in 16-bit word units, matching the controller `adr_i`.
- DW, 16, data word width; equals 2×WIDTH of the controller.
- LEN_W, 8, width of the burst length field.
- MAX_BURST, 64, maximum words per CS# assertion; must be a power of two and ≥2.
- TIMEOUT, 255, maximum cycles in XFER with no beat before error.
- clk90  in  1  clock. All ports are sampled and driven on posedge clk90.
- rst  in  1  reset, asynchronous, active-high.
- req[1:0]  in  2  per-requester transfer request. Hold high until the matching done pulse.
- we[1:0]  in  2  1 = write, 0 = read. Sampled with req.
- reg_space[1:0]  in  2  1 = register space. Sampled with req.
- adr0, adr1  in  ADDR_LENGTH each  start word address.
- len0, len1  in  LEN_W each  burst length in words; 0 = null transfer.
- wdat0, wdat1  in  DW each  write data for the current beat.
- wready[1:0]  out  2  write beat consumed this cycle.
- rdat  out  DW  read data, shared by both ports.
- rvalid[1:0]  out  2  rdat valid for the indicated port.
- done[1:0]  out  2  one-cycle pulse when the burst completes.
- gnt[1:0]  out  2  one-hot current owner; 0 when idle.
- err  out  1  sticky error.
- hb_adr  out  ADDR_LENGTH; hb_dat_o  out  DW; hb_wrq, hb_rrq, hb_reg_space  out  1 each: controller request side.
- hb_ready, hb_valid, hb_busy, hb_error  in  1 each; hb_dat_i  in  DW: controller response side.

## Operation
- States: IDLE, ISSUE, XFER, RELEASE, ERROR. State encoding is one-hot.
- IDLE: arbitration happens only here. When exactly one req bit is high, that port wins. When both are high, the port other than last_grant wins.
  - On a win: set gnt and latch we, reg_space, adr, and len into the segment registers. Set remaining = len and seg_cnt = 0.
  - If len==0, pulse done on the next cycle, update last_grant, and stay in IDLE. No controller request is made.
  - Otherwise go to ISSUE.
- ISSUE: wait until hb_busy==0. Then drive hb_wrq (for we) or hb_rrq (for read) high, together with hb_adr and hb_reg_space, and go to XFER. Requests stay held until segment end.
- XFER: each beat decrements remaining and increments seg_cnt.
  - A write beat is hb_ready==1. wready[g] = hb_ready and hb_dat_o = wdat of the owner; both paths are combinational.
  - A read beat is hb_valid==1. rdat = hb_dat_i and rvalid[g] = hb_valid; both paths are combinational.
  - Segment end is the beat where remaining==1 or seg_cnt==MAX_BURST-1. On that beat, drop hb_wrq/hb_rrq and go to RELEASE.
- RELEASE: wait for hb_busy==0. Then:
  - If remaining>0: set hb_adr = hb_adr + MAX_BURST (modulo 2^ADDR_LENGTH), set seg_cnt = 0, and go to ISSUE.
  - Else: pulse done[g], set last_grant = g, clear gnt, and go to IDLE.
- Watchdog: counter cleared on every beat and on XFER entry. Reaching TIMEOUT goes to ERROR.
- hb_error==1 in any state goes to ERROR.
- ERROR: all hb requests are low, gnt = 0, err = 1, no done pulse. Exit only via rst.
- Changes on req, adr, or len while a port is granted are ignored.

## Timing
- Reset values:
  - state IDLE; last_grant = port 1, so port 0 wins first.
  - gnt, done, err, hb_wrq, hb_rrq, hb_reg_space = 0; hb_adr = 0.
  - wready and rvalid are 0 because they are gated by state.
- All state and hb_* request outputs are registered. wready, rvalid, rdat, and hb_dat_o are combinational.
- req sampled high at edge N in IDLE: gnt is valid after N. With hb_busy low at edge N+1, hb_rrq/hb_wrq are high after N+1.
- Last beat of the burst at edge M: request goes low after M. done pulses for one cycle after the first edge in RELEASE that sees hb_busy==0.
- Segment turnaround between RELEASE and ISSUE costs at least 2 cycles plus controller idle time.
- Simultaneous beat and hb_error: the beat is delivered, and the state still goes to ERROR.
- rst mid-burst: every output returns to its reset value immediately; the segment is abandoned.

## Test plan
- Single read: port 0, adr=0x100, len=4, hb_valid on 4 cycles → 4 rvalid[0] pulses with matching rdat; hb_rrq low after the 4th beat; one done[0] pulse.
- Contention: req=2'b11 from reset → port 0 granted first, then port 1. Repeat with both held → grants alternate 0,1,0,1.
- Segmentation: MAX_BURST=64, port 1 write, len=150, adr=0x1000 → three wrq segments at 0x1000, 0x1040, and 0x1080 with 64/64/22 wready beats; done[1] fires once.
- Null transfer: len=0 → done pulse after 1 cycle; hb_wrq and hb_rrq never assert.
- Errors:
  - hb_error pulsed mid-XFER → err=1, requests drop, gnt=0, no done.
  - No beats for TIMEOUT cycles → err=1.
  - Both cases: err stays set until rst.
- Async reset during segment 2 of a long write → all outputs return to reset values in the same cycle. The next request after reset is granted normally.

Source files
------------

// File: rtl/hbus_arbiter_if.sv
// Requester-side and HyperBus-controller-side signals of hbus_arbiter.
// slave is the arbiter's view; master is the view of whatever drives requests and the controller.
interface hbus_arbiter_if #(
    parameter int unsigned ADDR_LENGTH = 32,
    parameter int unsigned DW          = 16,
    parameter int unsigned LEN_W       = 8
);
    logic [1:0]             req;
    logic [1:0]             we;
    logic [1:0]             reg_space;
    logic [ADDR_LENGTH-1:0] adr0;
    logic [ADDR_LENGTH-1:0] adr1;
    logic [LEN_W-1:0]       len0;
    logic [LEN_W-1:0]       len1;
    logic [DW-1:0]          wdat0;
    logic [DW-1:0]          wdat1;
    logic [1:0]             wready;
    logic [DW-1:0]          rdat;
    logic [1:0]             rvalid;
    logic [1:0]             done;
    logic [1:0]             gnt;
    logic                   err;

    logic [ADDR_LENGTH-1:0] hb_adr;
    logic [DW-1:0]          hb_dat_o;
    logic                   hb_wrq;
    logic                   hb_rrq;
    logic                   hb_reg_space;
    logic                   hb_ready;
    logic                   hb_valid;
    logic                   hb_busy;
    logic                   hb_error;
    logic [DW-1:0]          hb_dat_i;

    modport slave (
        input  req, we, reg_space, adr0, adr1, len0, len1, wdat0, wdat1,
        input  hb_ready, hb_valid, hb_busy, hb_error, hb_dat_i,
        output wready, rdat, rvalid, done, gnt, err,
        output hb_adr, hb_dat_o, hb_wrq, hb_rrq, hb_reg_space
    );

    modport master (
        output req, we, reg_space, adr0, adr1, len0, len1, wdat0, wdat1,
        output hb_ready, hb_valid, hb_busy, hb_error, hb_dat_i,
        input  wready, rdat, rvalid, done, gnt, err,
        input  hb_adr, hb_dat_o, hb_wrq, hb_rrq, hb_reg_space
    );
endinterface

// File: rtl/hbus_arbiter.sv
// Round-robin two-port arbiter in front of the HyperBus controller; splits bursts into
// segments of at most MAX_BURST words and watches the controller for errors and stalls.
module hbus_arbiter #(
    parameter int unsigned ADDR_LENGTH = 32,
    parameter int unsigned DW          = 16,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned MAX_BURST   = 64,
    parameter int unsigned TIMEOUT     = 255
) (
    input logic           clk90,
    input logic           rst,
    hbus_arbiter_if.slave bus
);
    localparam int unsigned SegW = $clog2(MAX_BURST);
    localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

    typedef enum logic [4:0] {
        StIdle    = 5'b00001,
        StIssue   = 5'b00010,
        StXfer    = 5'b00100,
        StRelease = 5'b01000,
        StError   = 5'b10000
    } state_e;

    state_e                 r_state, w_state_nxt;
    logic [1:0]             r_gnt, w_gnt_nxt;
    logic [1:0]             r_done, w_done_nxt;
    logic                   r_owner, w_owner_nxt;
    logic                   r_last, w_last_nxt;
    logic                   r_we, w_we_nxt;
    logic                   r_reg, w_reg_nxt;
    logic                   r_err, w_err_nxt;
    logic                   r_wrq, w_wrq_nxt;
    logic                   r_rrq, w_rrq_nxt;
    logic [ADDR_LENGTH-1:0] r_adr, w_adr_nxt;
    logic [LEN_W-1:0]       r_rem, w_rem_nxt;
    logic [SegW-1:0]        r_seg, w_seg_nxt;
    logic [WdW-1:0]         r_wdog, w_wdog_nxt;

    logic                   w_pick;
    logic [1:0]             w_win;
    logic [ADDR_LENGTH-1:0] w_sel_adr;
    logic [LEN_W-1:0]       w_sel_len;
    logic                   w_beat;
    logic                   w_seg_end;
    logic                   w_xfer;

    // With both requesting, the port that did not finish last wins.
    assign w_pick    = (bus.req == 2'b11) ? ~r_last : bus.req[1];
    assign w_win     = w_pick ? 2'b10 : 2'b01;
    assign w_sel_adr = w_pick ? bus.adr1 : bus.adr0;
    assign w_sel_len = w_pick ? bus.len1 : bus.len0;
    assign w_beat    = r_we ? bus.hb_ready : bus.hb_valid;
    assign w_seg_end = (r_rem == LEN_W'(1)) || (r_seg == SegW'(MAX_BURST - 1));
    assign w_xfer    = (r_state == StXfer);

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = 2'b00;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_we_nxt    = r_we;
        w_reg_nxt   = r_reg;
        w_err_nxt   = r_err;
        w_wrq_nxt   = r_wrq;
        w_rrq_nxt   = r_rrq;
        w_adr_nxt   = r_adr;
        w_rem_nxt   = r_rem;
        w_seg_nxt   = r_seg;
        w_wdog_nxt  = r_wdog;

        unique case (r_state)
            StIdle: begin
                w_gnt_nxt = 2'b00;
                // No arbitration in the done cycle, so the finishing requester can drop req.
                if (bus.req != 2'b00 && r_done == 2'b00) begin
                    w_gnt_nxt   = w_win;
                    w_owner_nxt = w_pick;
                    w_we_nxt    = bus.we[w_pick];
                    w_reg_nxt   = bus.reg_space[w_pick];
                    w_adr_nxt   = w_sel_adr;
                    w_rem_nxt   = w_sel_len;
                    w_seg_nxt   = '0;
                    if (w_sel_len == '0) begin
                        w_done_nxt = w_win;
                        w_last_nxt = w_pick;
                    end else begin
                        w_state_nxt = StIssue;
                    end
                end
            end
            StIssue: begin
                if (!bus.hb_busy) begin
                    w_wrq_nxt   = r_we;
                    w_rrq_nxt   = ~r_we;
                    w_wdog_nxt  = '0;
                    w_state_nxt = StXfer;
                end
            end
            StXfer: begin
                if (w_beat) begin
                    w_rem_nxt  = r_rem - LEN_W'(1);
                    w_seg_nxt  = r_seg + SegW'(1);
                    w_wdog_nxt = '0;
                    if (w_seg_end) begin
                        w_wrq_nxt   = 1'b0;
                        w_rrq_nxt   = 1'b0;
                        w_state_nxt = StRelease;
                    end
                end else if (r_wdog == WdW'(TIMEOUT - 1)) begin
                    w_state_nxt = StError;
                end else begin
                    w_wdog_nxt = r_wdog + WdW'(1);
                end
            end
            StRelease: begin
                if (!bus.hb_busy) begin
                    if (r_rem != '0) begin
                        w_adr_nxt   = r_adr + ADDR_LENGTH'(MAX_BURST);
                        w_seg_nxt   = '0;
                        w_state_nxt = StIssue;
                    end else begin
                        w_done_nxt  = r_gnt;
                        w_last_nxt  = r_owner;
                        w_gnt_nxt   = 2'b00;
                        w_state_nxt = StIdle;
                    end
                end
            end
            StError: begin
            end
            default: w_state_nxt = StError;
        endcase

        if (bus.hb_error || w_state_nxt == StError) begin
            w_state_nxt = StError;
            w_gnt_nxt   = 2'b00;
            w_done_nxt  = 2'b00;
            w_wrq_nxt   = 1'b0;
            w_rrq_nxt   = 1'b0;
            w_err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_reg   <= 1'b0;
            r_err   <= 1'b0;
            r_wrq   <= 1'b0;
            r_rrq   <= 1'b0;
            r_adr   <= '0;
            r_rem   <= '0;
            r_seg   <= '0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_we    <= w_we_nxt;
            r_reg   <= w_reg_nxt;
            r_err   <= w_err_nxt;
            r_wrq   <= w_wrq_nxt;
            r_rrq   <= w_rrq_nxt;
            r_adr   <= w_adr_nxt;
            r_rem   <= w_rem_nxt;
            r_seg   <= w_seg_nxt;
            r_wdog  <= w_wdog_nxt;
        end
    end

    assign bus.wready       = (w_xfer && r_we && bus.hb_ready) ? r_gnt : 2'b00;
    assign bus.rvalid       = (w_xfer && !r_we && bus.hb_valid) ? r_gnt : 2'b00;
    assign bus.rdat         = bus.hb_dat_i;
    assign bus.hb_dat_o     = r_owner ? bus.wdat1 : bus.wdat0;
    assign bus.done         = r_done;
    assign bus.gnt          = r_gnt;
    assign bus.err          = r_err;
    assign bus.hb_adr       = r_adr;
    assign bus.hb_wrq       = r_wrq;
    assign bus.hb_rrq       = r_rrq;
    assign bus.hb_reg_space = r_reg;
endmodule

// File: tb/tb_hbus_arbiter.sv
// Bench for hbus_arbiter: a segment-level scoreboard plus a simple controller model,
// with directed scenarios and literal expectations.
`timescale 1ns/1ps
module tb_hbus_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 16;
    localparam int unsigned LW = 8;
    localparam int unsigned MB = 64;
    localparam int unsigned TO = 255;

    logic clk90 = 1'b0;
    logic rst;
    always #5 clk90 = ~clk90;

    hbus_arbiter_if #(.ADDR_LENGTH(AW), .DW(DW), .LEN_W(LW)) bus ();

    hbus_arbiter #(
        .ADDR_LENGTH(AW), .DW(DW), .LEN_W(LW), .MAX_BURST(MB), .TIMEOUT(TO)
    ) dut (
        .clk90(clk90),
        .rst  (rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: each transfer expands to segments of at most MB words at adr + k*MB.
    typedef struct {
        int             port;
        bit             we;
        bit             rs;
        logic [AW-1:0]  adr;
        int             beats;
    } seg_t;

    seg_t          exp_q[$];
    logic [AW-1:0] log_adr[$];
    int            log_beats[$];
    logic [1:0]    gnt_log[$];
    logic [DW-1:0] rdat_log[$];
    int            done_seen[2] = '{0, 0};
    bit            any_req_seen;
    bit            stall;
    bit            gap_mode;

    task automatic push_xfer(input int p, input bit w, input bit rs, input logic [AW-1:0] a,
                             input int len);
        int            rem;
        logic [AW-1:0] sa;
        rem = len;
        sa  = a;
        while (rem > 0) begin
            seg_t s;
            s.port  = p;
            s.we    = w;
            s.rs    = rs;
            s.adr   = sa;
            s.beats = (rem > int'(MB)) ? int'(MB) : rem;
            exp_q.push_back(s);
            rem -= s.beats;
            sa  += AW'(MB);
        end
    endtask

    // Monitor: routing checks every cycle, segment checks at request rise and fall.
    bit            in_seg;
    seg_t          cur;
    int            cur_beats;
    logic [AW-1:0] cur_adr;
    logic [1:0]    gnt_prev;

    always @(negedge clk90) begin
        if (rst) begin
            in_seg   = 1'b0;
            gnt_prev = 2'b00;
            exp_q.delete();
            log_adr.delete();
            log_beats.delete();
            gnt_log.delete();
            rdat_log.delete();
        end else begin
            check("wready", bus.wready, (bus.hb_wrq && bus.hb_ready) ? bus.gnt : 2'b00);
            check("rvalid", bus.rvalid, (bus.hb_rrq && bus.hb_valid) ? bus.gnt : 2'b00);
            if (bus.rvalid != 2'b00) check("rdat", bus.rdat, bus.hb_dat_i);
            if (bus.hb_wrq) check("hb_dat_o", bus.hb_dat_o, bus.gnt[1] ? bus.wdat1 : bus.wdat0);
            if (bus.rvalid[0]) rdat_log.push_back(bus.rdat);
            if (bus.gnt != 2'b00 && gnt_prev == 2'b00) gnt_log.push_back(bus.gnt);
            gnt_prev = bus.gnt;
            for (int p = 0; p < 2; p++) if (bus.done[p]) done_seen[p]++;

            if (bus.hb_wrq || bus.hb_rrq) begin
                any_req_seen = 1'b1;
                if (!in_seg) begin
                    in_seg    = 1'b1;
                    cur_beats = 0;
                    cur_adr   = bus.hb_adr;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL seg_start: unexpected segment at adr %0h", bus.hb_adr);
                        cur.beats = -1;
                    end else begin
                        cur = exp_q.pop_front();
                        check("seg_adr", bus.hb_adr, cur.adr);
                        check("seg_wrq", bus.hb_wrq, cur.we);
                        check("seg_rrq", bus.hb_rrq, !cur.we);
                        check("seg_rs", bus.hb_reg_space, cur.rs);
                        check("seg_gnt", bus.gnt, 2'b01 << cur.port);
                    end
                end
                if (bus.hb_wrq ? bus.hb_ready : bus.hb_valid) cur_beats++;
            end else if (in_seg) begin
                in_seg = 1'b0;
                if (bus.err) begin
                    exp_q.delete();
                end else begin
                    check("seg_beats", cur_beats, cur.beats);
                    log_adr.push_back(cur_adr);
                    log_beats.push_back(cur_beats);
                end
            end
        end
    end

    // Controller model: busy while requested and 2 cycles after; beats when not stalled.
    int cyc;
    int rd_cnt;
    int busy_tail;
    bit active;

    initial begin
        cyc = 0; rd_cnt = 0; busy_tail = 0;
        bus.hb_ready = 1'b0; bus.hb_valid = 1'b0; bus.hb_busy = 1'b0;
        bus.hb_dat_i = '0; bus.wdat0 = '0; bus.wdat1 = '0;
        forever begin
            @(posedge clk90);
            #1;
            cyc++;
            if (rst) begin
                rd_cnt    = 0;
                busy_tail = 0;
            end else if (bus.hb_valid) begin
                rd_cnt++;
            end
            if (bus.hb_wrq || bus.hb_rrq) busy_tail = 2;
            else if (busy_tail > 0) busy_tail--;
            bus.hb_busy  = bus.hb_wrq || bus.hb_rrq || (busy_tail > 0);
            active       = !stall && (!gap_mode || (cyc % 3) != 0);
            bus.hb_ready = bus.hb_wrq && active;
            bus.hb_valid = bus.hb_rrq && active;
            bus.hb_dat_i = 16'hA000 + 16'(rd_cnt);
            bus.wdat0    = 16'h0C00 ^ 16'(cyc);
            bus.wdat1    = 16'h0D00 ^ 16'(cyc);
        end
    end

    task automatic do_reset();
        rst      = 1'b1;
        bus.req  = 2'b00;
        bus.hb_error = 1'b0;
        stall    = 1'b0;
        gap_mode = 1'b0;
        repeat (3) @(posedge clk90);
        #2 rst = 1'b0;
        @(negedge clk90);
    endtask

    task automatic set_port(input int p, input bit w, input bit rs, input logic [AW-1:0] a,
                            input logic [LW-1:0] l);
        bus.we[p]        = w;
        bus.reg_space[p] = rs;
        if (p == 0) begin
            bus.adr0 = a;
            bus.len0 = l;
        end else begin
            bus.adr1 = a;
            bus.len1 = l;
        end
    endtask

    // Issues one transfer and holds req until done; lat counts cycles to the done pulse.
    task automatic run_xfer(input int p, input bit w, input bit rs, input logic [AW-1:0] a,
                            input logic [LW-1:0] l, output int lat);
        push_xfer(p, w, rs, a, int'(l));
        set_port(p, w, rs, a, l);
        bus.req[p] = 1'b1;
        lat = 0;
        while (!bus.done[p] && lat < 2000) begin
            @(negedge clk90);
            lat++;
        end
        checks++;
        if (!bus.done[p]) begin
            errors++;
            $display("FAIL done_wait: port %0d no done within %0d cycles", p, lat);
        end
        bus.req[p] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, bus.gnt, 2'b00);
        check({tag, "_done"}, bus.done, 2'b00);
        check({tag, "_err"}, bus.err, 1'b0);
        check({tag, "_wrq"}, bus.hb_wrq, 1'b0);
        check({tag, "_rrq"}, bus.hb_rrq, 1'b0);
        check({tag, "_rs"}, bus.hb_reg_space, 1'b0);
        check({tag, "_adr"}, bus.hb_adr, 32'h0);
        check({tag, "_wready"}, bus.wready, 2'b00);
        check({tag, "_rvalid"}, bus.rvalid, 2'b00);
    endtask

    initial begin
        int lat;
        int d0;
        int d1;
        int cnt[2];
        int n;
        logic [DW-1:0] rexp;

        bus.req = 2'b00; bus.we = 2'b00; bus.reg_space = 2'b00;
        bus.adr0 = '0; bus.adr1 = '0; bus.len0 = '0; bus.len1 = '0;
        bus.hb_error = 1'b0;
        stall = 1'b0; gap_mode = 1'b0; any_req_seen = 1'b0;
        rst = 1'b1;
        #12;
        check_reset_outputs("rst");
        do_reset();
        check_reset_outputs("post_rst");

        // Single read, register space, no gaps: win, 1 issue cycle, 4 beats, 2 busy cycles.
        d0 = done_seen[0];
        run_xfer(0, 1'b0, 1'b1, 32'h100, 8'd4, lat);
        check("rd_lat", lat, 8);
        @(negedge clk90);
        check("rd_done_cnt", done_seen[0] - d0, 1);
        check("rd_nseg", log_adr.size(), 1);
        if (log_adr.size() == 1) begin
            check("rd_seg_adr", log_adr[0], 32'h100);
            check("rd_seg_beats", log_beats[0], 4);
        end
        check("rd_nbeats", rdat_log.size(), 4);
        for (int i = 0; i < rdat_log.size() && i < 4; i++) begin
            rexp = 16'hA000 + 16'(i);
            check("rd_data", rdat_log[i], rexp);
        end

        // Null transfer: done one cycle after the win, no controller request.
        do_reset();
        any_req_seen = 1'b0;
        d1 = done_seen[1];
        run_xfer(1, 1'b1, 1'b0, 32'h55, 8'd0, lat);
        check("null_lat", lat, 1);
        repeat (5) @(negedge clk90);
        check("null_no_req", any_req_seen, 1'b0);
        check("null_done_cnt", done_seen[1] - d1, 1);

        // Segmentation with gaps: 150 words split 64/64/22.
        do_reset();
        gap_mode = 1'b1;
        d0 = done_seen[0];
        d1 = done_seen[1];
        run_xfer(1, 1'b1, 1'b0, 32'h1000, 8'd150, lat);
        @(negedge clk90);
        check("seg_n", log_adr.size(), 3);
        if (log_adr.size() == 3) begin
            check("seg0_adr", log_adr[0], 32'h1000);
            check("seg1_adr", log_adr[1], 32'h1040);
            check("seg2_adr", log_adr[2], 32'h1080);
            check("seg0_beats", log_beats[0], 64);
            check("seg1_beats", log_beats[1], 64);
            check("seg2_beats", log_beats[2], 22);
        end
        check("seg_done1", done_seen[1] - d1, 1);
        check("seg_done0", done_seen[0] - d0, 0);

        // Contention from reset: both held for two transfers each, grants alternate.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            push_xfer(0, 1'b0, 1'b0, 32'h10, 2);
            push_xfer(1, 1'b1, 1'b0, 32'h20, 3);
        end
        set_port(0, 1'b0, 1'b0, 32'h10, 8'd2);
        set_port(1, 1'b1, 1'b0, 32'h20, 8'd3);
        cnt[0] = 0; cnt[1] = 0; n = 0;
        bus.req = 2'b11;
        while ((cnt[0] < 2 || cnt[1] < 2) && n < 1000) begin
            @(negedge clk90);
            n++;
            for (int p = 0; p < 2; p++) begin
                if (bus.done[p]) begin
                    cnt[p]++;
                    if (cnt[p] == 2) bus.req[p] = 1'b0;
                end
            end
        end
        bus.req = 2'b00;
        check("cont_done0", cnt[0], 2);
        check("cont_done1", cnt[1], 2);
        check("cont_ngnt", gnt_log.size(), 4);
        if (gnt_log.size() == 4) begin
            check("cont_g0", gnt_log[0], 2'b01);
            check("cont_g1", gnt_log[1], 2'b10);
            check("cont_g2", gnt_log[2], 2'b01);
            check("cont_g3", gnt_log[3], 2'b10);
        end

        // hb_error mid-write: the coincident beat is still delivered, then sticky error.
        do_reset();
        push_xfer(0, 1'b1, 1'b0, 32'h300, 10);
        set_port(0, 1'b1, 1'b0, 32'h300, 8'd10);
        bus.req[0] = 1'b1;
        n = 0;
        while (!bus.hb_wrq && n < 50) begin
            @(negedge clk90);
            n++;
        end
        check("err_wrq_seen", bus.hb_wrq, 1'b1);
        repeat (3) @(negedge clk90);
        d0 = done_seen[0];
        bus.hb_error = 1'b1;
        #1 check("err_beat_wready", bus.wready, 2'b01);
        @(negedge clk90);
        bus.hb_error = 1'b0;
        bus.req[0] = 1'b0;
        check("err_set", bus.err, 1'b1);
        check("err_wrq", bus.hb_wrq, 1'b0);
        check("err_rrq", bus.hb_rrq, 1'b0);
        check("err_gnt", bus.gnt, 2'b00);
        repeat (20) @(negedge clk90);
        check("err_sticky", bus.err, 1'b1);
        check("err_no_done", done_seen[0] - d0, 0);
        do_reset();
        check("err_cleared", bus.err, 1'b0);

        // Watchdog: stalled read errors exactly TIMEOUT cycles after entering XFER.
        do_reset();
        stall = 1'b1;
        push_xfer(1, 1'b0, 1'b0, 32'h400, 5);
        set_port(1, 1'b0, 1'b0, 32'h400, 8'd5);
        bus.req[1] = 1'b1;
        n = 0;
        while (!bus.hb_rrq && n < 50) begin
            @(negedge clk90);
            n++;
        end
        check("wd_rrq_seen", bus.hb_rrq, 1'b1);
        repeat (TO - 1) @(negedge clk90);
        check("wd_not_yet", bus.err, 1'b0);
        @(negedge clk90);
        check("wd_err", bus.err, 1'b1);
        check("wd_rrq_drop", bus.hb_rrq, 1'b0);
        check("wd_gnt", bus.gnt, 2'b00);
        bus.req[1] = 1'b0;
        repeat (10) @(negedge clk90);
        check("wd_sticky", bus.err, 1'b1);

        // Asynchronous reset during segment 2 of a long write, then a normal transfer.
        do_reset();
        push_xfer(1, 1'b1, 1'b0, 32'h2000, 150);
        set_port(1, 1'b1, 1'b0, 32'h2000, 8'd150);
        bus.req[1] = 1'b1;
        n = 0;
        while (!(bus.hb_wrq && bus.hb_adr == 32'h2040) && n < 300) begin
            @(negedge clk90);
            n++;
        end
        check("ar_seg2_seen", bus.hb_adr, 32'h2040);
        repeat (5) @(negedge clk90);
        @(posedge clk90);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async");
        bus.req = 2'b00;
        @(posedge clk90);
        #2 rst = 1'b0;
        @(negedge clk90);
        d0 = done_seen[0];
        run_xfer(0, 1'b0, 1'b0, 32'h40, 8'd3, lat);
        check("ar_lat", lat, 7);
        @(negedge clk90);
        check("ar_done", done_seen[0] - d0, 1);
        check("ar_gnt_n", gnt_log.size(), 1);
        if (gnt_log.size() == 1) check("ar_gnt", gnt_log[0], 2'b01);

        repeat (3) @(negedge clk90);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end
endmodule
